button_event_detector: RTL and testbench
========================================

// Module: button_event_detector
// PURPOSE
//  Downstream stage of slow_input_flop. Debounces its registered slow input
//  and emits single-cycle press/release/long-press events. Also raises a held
//  capture request (cap_req/cap_ack handshake) toward the image-capture
//  controller on each debounced press.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive identical samples needed to accept a level change (>=2)
//  HOLD_CYCLES      16  cycles in PRESSED before long_press fires (>=2)
//  CNT_W            16  counter width; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES)
//  ACTIVE_LOW       1   1: in==0 means pressed; 0: in==1 means pressed
// PORTS
//  clk         in   1  system clock; single clock domain
//  rst         in   1  synchronous, active-low reset
//  in          in   1  synchronized slow input (slow_input_flop.out)
//  db_level    out  1  debounced level, 1 = pressed
//  press       out  1  1-cycle pulse on debounced press
//  release     out  1  1-cycle pulse on debounced release
//  long_press  out  1  1-cycle pulse after HOLD_CYCLES in PRESSED; once per press
//  cap_req     out  1  capture request, held until acknowledged
//  cap_ack     in   1  capture acknowledge from consumer
//  dropped     out  1  sticky: press occurred while a request was still pending
// BEHAVIOUR
//  - Single clock, one process domain. rst sampled on clk rising edge. While rst==0:
//    state=IDLE, counters=0, all outputs 0, regardless of in or cap_ack.
//  - raw = ACTIVE_LOW ? ~in : in. All outputs registered.
//  - FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
//  - IDLE: raw=1 -> PRESS_WAIT, dcnt=1. Else stay.
//  - PRESS_WAIT: raw=0 -> IDLE, dcnt=0 (bounce rejected, no event).
//    raw=1 and dcnt==DEBOUNCE_CYCLES-1 -> PRESSED; db_level<=1; press<=1; hcnt=0.
//    Else dcnt++.
//    Net: press is registered on the edge that samples the DEBOUNCE_CYCLES-th
//    consecutive asserted raw.
//  - PRESSED: hcnt++ saturating at HOLD_CYCLES; long_press<=1 on the edge where
//    hcnt goes HOLD_CYCLES-1 -> HOLD_CYCLES. Never repeats within one press.
//    raw=0 -> RELEASE_WAIT, dcnt=1.
//  - RELEASE_WAIT: hcnt keeps counting; long_press may still fire here.
//    raw=1 -> PRESSED, dcnt=0.
//    raw=0 and dcnt==DEBOUNCE_CYCLES-1 -> IDLE; db_level<=0; release<=1.
//    Else dcnt++.
//  - press, release and long_press are high for exactly one cycle. press and
//    release are never high in the same cycle.
//  - Capture handshake (evaluated every cycle, priority in order):
//    - ack = cap_ack & cap_req; cap_ack while cap_req==0 is ignored.
//    - next cap_req = (cap_req & ~ack) | press_event.
//    - press_event with cap_req==1 and no ack same cycle -> dropped<=1.
//    - Press and ack in the same cycle: old request retired, new one issued;
//      cap_req stays 1, dropped unchanged.
//    - cap_req falls on the edge after the acknowledging cycle.
//    - dropped is cleared only by reset.
//  - Counters saturate and never wrap. Reset mid-operation abandons any
//    pending request and suppresses all events.
// TESTING  (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, ACTIVE_LOW=1, 20ns clk)
//  1. rst=0 for 2 cycles with in=1, then release rst
//     -> db_level, press, release, long_press, cap_req and dropped all 0 throughout.
//  2. in=0 for 8 cycles, then in=1
//     -> press=1 for 1 cycle on the 4th low sample; db_level=1;
//     -> release 1 cycle on the 4th high sample; db_level=0; cap_req=1 from the press edge.
//  3. Bounce: in=0 for 3 cycles, 1 for 1, 0 for 3, then 1
//     -> no press, db_level and cap_req stay 0.
//  4. in=0 for 24 cycles
//     -> press at sample 4; long_press exactly once, 16 cycles after press; no repeat.
//  5. Two debounced presses, no ack -> cap_req=1, dropped=1.
//     cap_ack=1 for 1 cycle -> cap_req=0 next edge.
//     New press coincident with cap_ack -> cap_req stays 1.
//  6. rst=0 asserted during PRESS_WAIT (2 low samples) and during pending cap_req
//     -> all outputs 0 next edge; no press is emitted after rst returns high.

Source files
------------

// File: rtl/button_event_detector.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// button_event_detector
//
// Purpose
//   Debounces the synchronized slow input coming from slow_input_flop and turns
//   it into clean single-cycle events: press, release and long press. Each
//   debounced press also raises a capture request toward the image-capture
//   controller. The request is held until that controller acknowledges it.
//
// Ports
//   clk            in   system clock (single domain)
//   rst            in   synchronous reset, active low
//   in             in   synchronized slow input (slow_input_flop.out)
//   db_level       out  debounced level, 1 = pressed
//   press          out  1-cycle pulse on a debounced press
//   release_pulse  out  1-cycle pulse on a debounced release
//                       ("release" is a reserved word in SystemVerilog)
//   long_press     out  1-cycle pulse HOLD_CYCLES after press, once per press
//   cap_req        out  capture request, held until acknowledged
//   cap_ack        in   capture acknowledge from the consumer
//   dropped        out  sticky: a press arrived while a request was pending
//   dbg_state      out  current FSM state encoding (observation only)
//
// Handshake
//   A request is retired in any cycle where cap_ack and cap_req are both 1.
//   cap_req falls on the following edge. cap_ack is ignored while cap_req is 0.
//   A press in the same cycle as an acknowledge retires the old request and
//   issues a new one, so cap_req stays 1.
//
// Parameter constraints
//   DEBOUNCE_CYCLES >= 2, HOLD_CYCLES >= 2.
//   CNT_W must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES).
// -----------------------------------------------------------------------------
module button_event_detector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int CNT_W           = 16,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    output logic       db_level,
    output logic       press,
    output logic       release_pulse,
    output logic       long_press,
    output logic       cap_req,
    input  logic       cap_ack,
    output logic       dropped,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] dcnt_next;
    logic [CNT_W-1:0] dcnt_inc;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hcnt_next;
    logic [CNT_W-1:0] hcnt_inc;
    logic             db_next;
    logic             press_next;
    logic             release_next;
    logic             long_next;
    logic             req_next;
    logic             dropped_next;
    logic             raw;
    logic             ack;

    // raw is 1 whenever the button is physically pressed, whatever the polarity.
    assign raw = ACTIVE_LOW ? ~in : in;

    // An acknowledge counts only while a request is actually outstanding.
    assign ack = cap_ack & cap_req;

    // Both counters saturate. dcnt stops at its all-ones value. hcnt stops at
    // HOLD_CYCLES, so long_press cannot fire again within one press.
    assign dcnt_inc = (dcnt == CNT_MAX) ? dcnt : dcnt + ONE;
    assign hcnt_inc = (hcnt >= HOLD_MAX) ? HOLD_MAX : hcnt + ONE;

    assign dbg_state = state;

    // Next-state, counter and event logic
    always_comb begin
        state_next   = state;
        dcnt_next    = dcnt;
        hcnt_next    = hcnt;
        db_next      = db_level;
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = 1'b0;
        req_next     = 1'b0;
        dropped_next = dropped;

        case (state)
            IDLE: begin
                if (raw) begin
                    state_next = PRESS_WAIT;
                    dcnt_next  = ONE;
                end else begin
                    dcnt_next  = '0;
                end
            end

            PRESS_WAIT: begin
                if (!raw) begin
                    // Bounce: go back quietly without emitting an event.
                    state_next = IDLE;
                    dcnt_next  = '0;
                end else if (dcnt == DB_LAST) begin
                    // This edge samples the DEBOUNCE_CYCLES-th consecutive
                    // asserted raw, so the press is accepted here.
                    state_next = PRESSED;
                    db_next    = 1'b1;
                    press_next = 1'b1;
                    hcnt_next  = '0;
                    dcnt_next  = '0;
                end else begin
                    dcnt_next  = dcnt_inc;
                end
            end

            PRESSED: begin
                hcnt_next = hcnt_inc;
                if (!raw) begin
                    state_next = RELEASE_WAIT;
                    dcnt_next  = ONE;
                end else begin
                    dcnt_next  = '0;
                end
            end

            RELEASE_WAIT: begin
                // The hold timer keeps running through a release bounce, so a
                // long press can still mature while the release is pending.
                hcnt_next = hcnt_inc;
                if (raw) begin
                    state_next = PRESSED;
                    dcnt_next  = '0;
                end else if (dcnt == DB_LAST) begin
                    state_next   = IDLE;
                    db_next      = 1'b0;
                    release_next = 1'b1;
                    dcnt_next    = '0;
                end else begin
                    dcnt_next    = dcnt_inc;
                end
            end

            default: begin
                state_next = IDLE;
                dcnt_next  = '0;
                hcnt_next  = '0;
            end
        endcase

        // long_press fires on the single edge where hcnt moves from
        // HOLD_CYCLES-1 to HOLD_CYCLES.
        if ((state == PRESSED || state == RELEASE_WAIT) && hcnt == HOLD_LAST) begin
            long_next = 1'b1;
        end

        // Capture handshake: retire the acknowledged request, then issue a new
        // request on a press. A press that lands on an unacknowledged request
        // is recorded in the sticky dropped flag.
        req_next = (cap_req & ~ack) | press_next;
        if (press_next && cap_req && !ack) begin
            dropped_next = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            dcnt          <= '0;
            hcnt          <= '0;
            db_level      <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            cap_req       <= 1'b0;
            dropped       <= 1'b0;
        end else begin
            state         <= state_next;
            dcnt          <= dcnt_next;
            hcnt          <= hcnt_next;
            db_level      <= db_next;
            press         <= press_next;
            release_pulse <= release_next;
            long_press    <= long_next;
            cap_req       <= req_next;
            dropped       <= dropped_next;
        end
    end

endmodule

// File: tb/tb_button_event_detector.sv
`timescale 1ns/1ps
module tb_button_event_detector;

    localparam int DB   = 4;
    localparam int HOLD = 16;

    // ---------------- clock / reset ----------------
    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       in      = 1'b1;
    logic       cap_ack = 1'b0;
    logic       db_level;
    logic       press;
    logic       release_pulse;
    logic       long_press;
    logic       cap_req;
    logic       dropped;
    logic [1:0] dbg_state;

    always #10 clk = ~clk;

    button_event_detector #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HOLD),
        .CNT_W          (16),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in           (in),
        .db_level     (db_level),
        .press        (press),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .cap_req      (cap_req),
        .cap_ack      (cap_ack),
        .dropped      (dropped),
        .dbg_state    (dbg_state)
    );

    // ---------------- counters ----------------
    int checks = 0;
    int errors = 0;
    int n_press = 0;
    int n_release = 0;
    int n_long = 0;

    // ---------------- reference model ----------------
    // Level view: the debounced level flips once DB consecutive samples
    // disagree with it. A long press is due exactly HOLD edges after the press
    // edge if the level is still high going into that edge.
    logic   m_level   = 1'b0;
    logic   m_press   = 1'b0;
    logic   m_release = 1'b0;
    logic   m_long    = 1'b0;
    logic   m_req     = 1'b0;
    logic   m_dropped = 1'b0;
    int     m_run     = 0;
    longint edge_idx  = 0;
    longint press_edge = -1000;

    task automatic model_edge(input logic r, input logic i, input logic a);
        logic raw;
        logic old_level;
        logic ack_v;
        edge_idx++;
        m_press   = 1'b0;
        m_release = 1'b0;
        m_long    = 1'b0;
        if (!r) begin
            m_level    = 1'b0;
            m_run      = 0;
            m_req      = 1'b0;
            m_dropped  = 1'b0;
            press_edge = -1000;
            return;
        end
        raw       = ~i;
        old_level = m_level;
        if (raw != m_level) m_run++;
        else                m_run = 0;
        if (m_run == DB) begin
            m_level = ~m_level;
            m_run   = 0;
            if (m_level) begin
                m_press    = 1'b1;
                press_edge = edge_idx;
            end else begin
                m_release  = 1'b1;
            end
        end
        m_long = old_level && (edge_idx == press_edge + HOLD);
        ack_v  = a & m_req;
        if (m_press && m_req && !ack_v) m_dropped = 1'b1;
        m_req = (m_req & ~ack_v) | m_press;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b edge=%0d", tag, got, exp, edge_idx);
        end
    endtask

    // ---------------- driver ----------------
    task automatic tick(input logic r, input logic i, input logic a);
        rst     = r;
        in      = i;
        cap_ack = a;
        @(posedge clk);
        model_edge(r, i, a);
        #1;
        n_press   += int'(press === 1'b1);
        n_release += int'(release_pulse === 1'b1);
        n_long    += int'(long_press === 1'b1);
        check("db_level",   db_level,      m_level);
        check("press",      press,         m_press);
        check("release",    release_pulse, m_release);
        check("long_press", long_press,    m_long);
        check("cap_req",    cap_req,       m_req);
        check("dropped",    dropped,       m_dropped);
    endtask

    task automatic hold_in(input logic i, input int n);
        for (int k = 0; k < n; k++) tick(1'b1, i, 1'b0);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int p0;
        int r0;
        int l0;
        logic v;
        int len;

        // 1. reset with in idle, then release reset
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        check("reset_state_idle", logic'(dbg_state == 2'd0), 1'b1);
        hold_in(1'b1, 3);

        // 2. clean press and release
        p0 = n_press; r0 = n_release;
        hold_in(1'b0, 8);
        check("t2_one_press", logic'(n_press == p0 + 1), 1'b1);
        check("t2_level_high", db_level, 1'b1);
        check("t2_cap_req_set", cap_req, 1'b1);
        hold_in(1'b1, 8);
        check("t2_one_release", logic'(n_release == r0 + 1), 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        check("t2_cap_req_acked", cap_req, 1'b0);

        // 3. bounce rejected
        p0 = n_press;
        hold_in(1'b0, 3);
        hold_in(1'b1, 1);
        hold_in(1'b0, 3);
        hold_in(1'b1, 6);
        check("t3_no_press", logic'(n_press == p0), 1'b1);
        check("t3_cap_req_low", cap_req, 1'b0);

        // 4. long press, exactly once
        l0 = n_long; p0 = n_press;
        hold_in(1'b0, 24);
        hold_in(1'b1, 6);
        check("t4_one_press", logic'(n_press == p0 + 1), 1'b1);
        check("t4_one_long", logic'(n_long == l0 + 1), 1'b1);

        // 5. second press without ack -> dropped; ack; press coincident with ack
        hold_in(1'b0, 6);
        hold_in(1'b1, 6);
        check("t5_dropped", dropped, 1'b1);
        check("t5_req_pending", cap_req, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        check("t5_req_retired", cap_req, 1'b0);
        hold_in(1'b0, 5);
        hold_in(1'b1, 6);
        hold_in(1'b0, 3);
        tick(1'b1, 1'b0, 1'b1);
        check("t5_press_with_ack", press, 1'b1);
        check("t5_req_stays", cap_req, 1'b1);
        hold_in(1'b0, 2);
        hold_in(1'b1, 6);

        // 6. reset during PRESS_WAIT and during a pending request
        hold_in(1'b0, 2);
        tick(1'b0, 1'b0, 1'b0);
        check("t6_req_cleared", cap_req, 1'b0);
        check("t6_dropped_cleared", dropped, 1'b0);
        p0 = n_press;
        hold_in(1'b1, 6);
        check("t6_no_press_after_rst", logic'(n_press == p0), 1'b1);
        hold_in(1'b0, 5);
        tick(1'b0, 1'b1, 1'b0);
        check("t6_pending_req_abandoned", cap_req, 1'b0);
        hold_in(1'b1, 4);

        // 7. randomized segments against the model
        for (int s = 0; s < 80; s++) begin
            v   = logic'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 26) : $urandom_range(1, 7);
            for (int k = 0; k < len; k++) begin
                tick(logic'($urandom_range(0, 79) != 0), v,
                     logic'($urandom_range(0, 3) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
